// File: rtl/pattern_ram_writer_pkg.sv
// Shared types and defaults for the run-time loadable pattern RAM.
package pattern_ram_writer_pkg;

    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 8;

    localparam logic [7:0] OOR_VAL = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pattern_mem.sv
// DEPTH x DW pattern storage: rising-edge write port, falling-edge registered
// read port matching the pattern ROM read timing.
module pattern_mem
    import pattern_ram_writer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int RAW   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [DW-1:0]  wdata,
    input  logic [RAW-1:0] raddr,
    output logic [DW-1:0]  rdata
);

    localparam logic [RAW-1:0] DEPTH_R = RAW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // Storage is intentionally not reset: entries survive reset and restarts.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = DW'(OOR_VAL);
        if (raddr < DEPTH_R) begin
            rdata_d = mem[raddr[AW-1:0]];
        end
    end

    // Falling-edge capture gives half-cycle write-through after a rising-edge write.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pattern_ram_writer.sv
// Streams pattern bytes over valid/ready into pattern_mem and reports the
// length of the last completed load.
module pattern_ram_writer
    import pattern_ram_writer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          commit,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   len,
    input  logic [7:0]    adress,
    output logic [DW-1:0] out
);

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   len_q, len_d;
    logic          accept;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
        end
    end

    // A restart in the same cycle swallows any offered byte.
    assign accept = (state_q == ST_LOAD) && din_valid && !start;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        len_d   = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    wptr_d  = '0;
                end
            end
            ST_LOAD: begin
                if (start) begin
                    wptr_d = '0;
                end else if (commit) begin
                    state_d = ST_DONE;
                    len_d   = {1'b0, wptr_q} + {{AW{1'b0}}, accept};
                end else if (accept) begin
                    wptr_d = wptr_q + 1'b1;
                    if (wptr_q == AW'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                        len_d   = (AW+1)'(DEPTH);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign din_ready = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_LOAD);
    assign done      = (state_q == ST_DONE);
    assign len       = len_q;

    pattern_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .RAW   (8)
    ) u_mem (
        .clk   (clk),
        .rst_n (rstn),
        .we    (accept),
        .waddr (wptr_q),
        .wdata (din),
        .raddr (adress),
        .rdata (out)
    );

endmodule

// File: doc/pattern_ram_writer.md
# pattern_ram_writer

Writable counterpart to the pattern ROM: accepts a stream of 8-bit pump/motor pattern bytes over a valid/ready handshake and stores them sequentially in a 32x8 RAM. The RAM exposes the same read port and read timing as the pattern ROM (byte address in, data registered on the falling clock edge), so sequencers can fetch patterns loaded at run time instead of fixed at synthesis.

## Interface
- DEPTH, 32, number of pattern entries
- AW, 5, write-pointer / internal address width (log2 DEPTH)
- DW, 8, pattern word width
- clk  in  1  system clock; writes on rising edge, read data on falling edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin a new load at entry 0
- commit  in  1  pulse: end the current load early
- din  in  DW  pattern byte to store
- din_valid  in  1  din holds a byte
- din_ready  out  1  block accepts din this cycle
- busy  out  1  load in progress
- done  out  1  one-cycle pulse: load finished, len updated
- len  out  AW+1  number of valid entries from the last completed load (0..DEPTH)
- adress  in  8  read address (sequencer side)
- out  out  DW  read data

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: din_ready=0, busy=0. start=1 -> LOAD, wptr<=0. commit ignored.
- LOAD: din_ready=1, busy=1. On din_valid&din_ready: mem[wptr]<=din, wptr<=wptr+1.
  - Accept at wptr=DEPTH-1 -> DONE, count=DEPTH.
  - commit=1 -> DONE, count=wptr plus 1 if a byte is accepted the same cycle.
  - start=1 (without commit) -> restart: wptr<=0, any byte offered that cycle is dropped (not accepted; din_ready stays 1 but acceptance is suppressed by start). start has priority over commit and over auto-finish.
- DONE: din_ready=0, busy=0, done=1 for exactly one cycle, len<=count (registered on the LOAD->DONE transition, so valid while done=1); next state IDLE. start in DONE ignored.
- len holds its value until the next completed load; an aborted (restarted or reset) load never updates it.
- Read: on falling clk, out <= mem[adress[AW-1:0]] when adress < DEPTH, else 8'h00. Reads are always enabled, including during LOAD (returns new or previous contents per entry).
- Memory is not cleared by reset or by start; entries beyond len hold stale data.

## Timing
- Reset (rstn=0, any time, including mid-load): state IDLE, wptr=0, len=0, done=0, din_ready=0, busy=0, out=8'h00. Load in progress is abandoned.
- din_ready is a function of registered state only (no combinational path from din_valid).
- Write-to-read: byte accepted at rising edge N is visible on out at the falling edge of cycle N if adress matches (half-cycle write-through).
- Read latency: out updates at the falling edge after adress settles; stable across the following rising edge.
- done rises one cycle after the final accept or commit; minimum start-to-done: 2 cycles (start, commit next cycle, len=0).
- Maximum load: DEPTH accepts back-to-back, done one cycle after the 32nd accept.

## Structure
- Shared package: state enum (IDLE/LOAD/DONE), DEPTH/AW/DW defaults, out-of-range read value (8'h00).
- Sub-module pattern_mem: DEPTH x DW storage, rising-edge write port (we, waddr, wdata), falling-edge registered read port with range check and reset of the read register. FSM, pointer and len live in the top.

## Test plan
- Reset then read adress 0..40 -> out=8'h00 after reset; len=0, din_ready=0, busy=0.
- start, stream 8'h01..8'h20 (32 bytes, valid held high) -> 32 accepts, done one cycle after last, len=32; read adress 5 -> 8'h06, adress 31 -> 8'h20, adress 32 -> 8'h00.
- start, 3 bytes AA,BB,CC with valid gaps, commit in same cycle as CC -> len=3, done pulse once; entry 3 keeps old value.
- start, 10 bytes, start again, 2 bytes 11,22, commit -> len=2; entry 0=11, entry 1=22, entries 2..9 hold first-pass bytes.
- Mid-load rstn low for 1 cycle after 5 accepts -> len=0, state IDLE, no done; previously written entries 0..4 still readable.
- Accept 8'h5A at adress 7 while adress=7 -> out=8'h5A at falling edge of the same cycle.
